plugin_recurrence: RTL and testbench
====================================

Name: plugin_recurrence

Overview:
Parametrised successor to the single-sequence Fibonacci plugin accelerator. It computes the n-th term of one of four integer linear recurrences, selected per operation: Fibonacci, Lucas, Tribonacci or Pell. It adds overflow reporting, an index-range error, and an abort input. It sits on the same RS5 plugin start/busy/done interface and is driven by the plugin dispatch logic from a custom R-type instruction (rd <- term, rs1 = n, rs2 = mode).

Parameters:
XLEN, 32, width of operands, result and internal term/counter registers
MAX_N, 1023, largest accepted index; any n > MAX_N is an error

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
abort  input  1  cancels an operation in progress; synchronous
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
operand_a  input  XLEN  index n, unsigned
operand_b  input  XLEN  bits[1:0] select the mode; upper bits are ignored
result  output  XLEN  term value; held until the next accepted start
ovf  output  1  the result wrapped modulo 2^XLEN; valid with done and held
err  output  1  n > MAX_N; valid with done and held

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous, active-low.
- Reset values: state=IDLE; busy=0, done=0, result=0, ovf=0, err=0; all internal registers 0.
- Modes (operand_b[1:0]) and seeds:
  - 0, Fibonacci: a0=0, a1=1; a(i)=a(i-1)+a(i-2).
  - 1, Lucas: a0=2, a1=1; same recurrence as Fibonacci.
  - 2, Tribonacci: a0=0, a1=0, a2=1; a(i)=a(i-1)+a(i-2)+a(i-3).
  - 3, Pell: a0=0, a1=1; a(i)=2*a(i-1)+a(i-2).
- First computed index: k0=3 for Tribonacci, k0=2 for all other modes.
- States:
  - IDLE: on start, latch n and mode and clear ovf/err. Next state INIT.
  - INIT: if n > MAX_N, set err=1, result=0, go to FINISH. Else if n < k0, set result to the seed a(n), go to FINISH. Else load the seeds, set counter=k0, go to CALC.
  - CALC: compute one term per cycle and increment counter. When counter==n, write the term to result and go to FINISH.
  - FINISH: assert done for one cycle, then return to IDLE.
- Timing: start is high in cycle 0. INIT occupies cycle 1. done is high in cycle L.
  - L=2 for base and error cases.
  - L=2+(n-k0+1) otherwise.
  - busy is high in cycles 1..L-1. It is low in the done cycle and in IDLE.
- start while busy, or in the FINISH cycle, is ignored; there is no queuing.
- Arithmetic: all sums are XLEN-bit, modulo 2^XLEN.
  - ovf is sticky within an operation. It is set if any carry out of bit XLEN-1 occurs in a term computation, including the doubling in Pell and either addition in Tribonacci.
  - ovf stays 0 for base and error cases.
- n is compared as a full-XLEN unsigned value; the counter never wraps because n <= MAX_N < 2^XLEN-1.
- abort in INIT or CALC: next state IDLE, busy drops the next cycle, no done pulse. result, ovf and err keep their pre-start values; they are cleared only at the final commit.
  - abort in IDLE or FINISH has no effect.
  - abort and start together in IDLE: start wins.
- reset_n low mid-operation: all outputs go to reset values immediately; no done pulse.
- Committed outputs: result, ovf and err update only on entry to FINISH, or in INIT for base/error cases. They stay stable until the next committed operation.

Test Plan:
- Fibonacci n=10 (operand_b=0) -> done at L=11; result=55, ovf=0, err=0; busy high in cycles 1..10.
- Lucas n=10 (mode 1) -> result=123, L=11. Lucas n=0 -> result=2, L=2.
- Tribonacci n=10 (mode 2) -> result=81, L=10. Tribonacci n=2 -> result=1, L=2. Pell n=7 (mode 3) -> result=169, L=8.
- Fibonacci n=47 -> result=2971215073, ovf=0. Fibonacci n=48 -> result=512559680, ovf=1.
- n=1024 with MAX_N=1023 -> err=1, result=0, L=2. A following n=5 operation -> result=5, err=0.
- Abort and reset:
  - Start Fibonacci n=20 after a prior result of 55, pulse abort in cycle 6 -> busy low from cycle 7, no done, result stays 55.
  - Assert reset_n=0 mid-CALC -> all outputs 0 asynchronously.
  - A start pulsed during busy is ignored; the original operation completes unchanged.

Source files
------------

// File: rtl/plugin_recurrence.sv
// Plugin accelerator computing the n-th term of Fibonacci, Lucas, Tribonacci or Pell.
// Start/busy/done handshake with overflow and index-range reporting plus abort.
module plugin_recurrence #(
    parameter int XLEN  = 32,
    parameter int MAX_N = 1023
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] result,
    output logic            ovf,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        CALC   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [1:0] MODE_FIB   = 2'd0;
    localparam logic [1:0] MODE_LUCAS = 2'd1;
    localparam logic [1:0] MODE_TRIB  = 2'd2;
    localparam logic [1:0] MODE_PELL  = 2'd3;

    state_t          state_reg;
    logic [XLEN-1:0] n_reg;
    logic [XLEN-1:0] cnt_reg;
    logic [1:0]      mode_reg;
    logic            ovf_acc_reg;
    // t2 holds a(i-1), t1 a(i-2), t0 a(i-3)
    logic [XLEN-1:0] t0_reg;
    logic [XLEN-1:0] t1_reg;
    logic [XLEN-1:0] t2_reg;

    logic [XLEN-1:0] k0;
    logic [XLEN-1:0] term_next;
    logic            carry_next;
    logic [XLEN:0]   sum_ab;
    logic [XLEN:0]   sum_pell;
    logic [XLEN:0]   sum_t1;
    logic [XLEN:0]   sum_t2;
    logic            unused_operand_b;

    assign unused_operand_b = ^operand_b[XLEN-1:2];

    assign k0 = (mode_reg == MODE_TRIB) ? XLEN'(3) : XLEN'(2);

    assign sum_ab   = {1'b0, t1_reg} + {1'b0, t2_reg};
    assign sum_pell = {1'b0, t2_reg[XLEN-2:0], 1'b0} + {1'b0, t1_reg};
    assign sum_t1   = {1'b0, t0_reg} + {1'b0, t1_reg};
    assign sum_t2   = {1'b0, sum_t1[XLEN-1:0]} + {1'b0, t2_reg};

    // Term value and carry for the current CALC step; Pell also carries out of the doubling
    always_comb begin
        term_next  = '0;
        carry_next = 1'b0;
        case (mode_reg)
            MODE_FIB, MODE_LUCAS: begin
                term_next  = sum_ab[XLEN-1:0];
                carry_next = sum_ab[XLEN];
            end
            MODE_TRIB: begin
                term_next  = sum_t2[XLEN-1:0];
                carry_next = sum_t1[XLEN] | sum_t2[XLEN];
            end
            default: begin
                term_next  = sum_pell[XLEN-1:0];
                carry_next = t2_reg[XLEN-1] | sum_pell[XLEN];
            end
        endcase
    end

    function automatic logic [XLEN-1:0] seed(input logic [1:0] m, input logic [1:0] i);
        logic [XLEN-1:0] v;
        v = '0;
        case (m)
            MODE_LUCAS: v = (i == 2'd0) ? XLEN'(2) : XLEN'(1);
            MODE_TRIB:  v = (i == 2'd2) ? XLEN'(1) : '0;
            default:    v = (i == 2'd1) ? XLEN'(1) : '0;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            ovf         <= 1'b0;
            err         <= 1'b0;
            n_reg       <= '0;
            cnt_reg     <= '0;
            mode_reg    <= '0;
            ovf_acc_reg <= 1'b0;
            t0_reg      <= '0;
            t1_reg      <= '0;
            t2_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        n_reg       <= operand_a;
                        mode_reg    <= operand_b[1:0];
                        ovf_acc_reg <= 1'b0;
                        busy        <= 1'b1;
                        state_reg   <= INIT;
                    end
                end
                INIT: begin
                    if (abort) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (n_reg > XLEN'(MAX_N)) begin
                        result    <= '0;
                        ovf       <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= FINISH;
                    end else if (n_reg < k0) begin
                        result    <= seed(mode_reg, n_reg[1:0]);
                        ovf       <= 1'b0;
                        err       <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= FINISH;
                    end else begin
                        // Seeds are the terms just below k0, oldest in t0
                        if (mode_reg == MODE_TRIB) begin
                            t0_reg <= seed(mode_reg, 2'd0);
                            t1_reg <= seed(mode_reg, 2'd1);
                            t2_reg <= seed(mode_reg, 2'd2);
                        end else begin
                            t0_reg <= '0;
                            t1_reg <= seed(mode_reg, 2'd0);
                            t2_reg <= seed(mode_reg, 2'd1);
                        end
                        cnt_reg   <= k0;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    if (abort) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (cnt_reg == n_reg) begin
                        result    <= term_next;
                        ovf       <= ovf_acc_reg | carry_next;
                        err       <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= FINISH;
                    end else begin
                        t0_reg      <= t1_reg;
                        t1_reg      <= t2_reg;
                        t2_reg      <= term_next;
                        ovf_acc_reg <= ovf_acc_reg | carry_next;
                        cnt_reg     <= cnt_reg + XLEN'(1);
                    end
                end
                default: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plugin_recurrence.sv
// Directed bench for plugin_recurrence: latency, results, ovf/err, abort, reset and ignored starts.
module tb_plugin_recurrence;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [31:0] result;
    logic        ovf;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    plugin_recurrence #(.XLEN(32), .MAX_N(1023)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start in cycle 0, then check busy/done every cycle up to L+1 and the committed outputs from L on.
    // inject>0 pulses a competing start in that cycle; abort_start raises abort together with start.
    task automatic run_op(input string tag, input int n, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ovf, input logic exp_err,
                          input int lat, input int inject, input logic abort_start);
        logic [1:0] exp_bd;
        @(negedge clk);
        start     = 1'b1;
        operand_a = 32'(n);
        operand_b = b;
        abort     = abort_start;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                abort = 1'b0;
            end
            if (inject != 0 && c == inject) begin
                start     = 1'b1;
                operand_a = 32'd3;
                operand_b = 32'd0;
            end else if (inject != 0 && c == inject + 1) begin
                start = 1'b0;
            end
            exp_bd = (c < lat) ? 2'b10 : ((c == lat) ? 2'b01 : 2'b00);
            check($sformatf("%s busy/done c%0d", tag, c), {30'b0, busy, done}, {30'b0, exp_bd});
            if (c >= lat) begin
                check($sformatf("%s result c%0d", tag, c), result, exp_res);
                check($sformatf("%s ovf c%0d", tag, c), {31'b0, ovf}, {31'b0, exp_ovf});
                check($sformatf("%s err c%0d", tag, c), {31'b0, err}, {31'b0, exp_err});
            end
        end
        start = 1'b0;
        $display("op %s n=%0d mode=%0d: result=%0d ovf=%0d err=%0d", tag, n, b[1:0], result, ovf, err);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset ovf/err", {30'b0, ovf, err}, 32'd0);
        reset_n = 1'b1;

        run_op("fib10", 10, 32'd0, 32'd55, 1'b0, 1'b0, 11, 0, 1'b0);

        // Abort in cycle 6 of a Fibonacci n=20 run: busy drops in cycle 7, no done, result kept
        @(negedge clk);
        start     = 1'b1;
        operand_a = 32'd20;
        operand_b = 32'd0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 6) abort = 1'b1;
            if (c == 7) abort = 1'b0;
            check($sformatf("abort busy/done c%0d", c), {30'b0, busy, done},
                  (c <= 6) ? 32'd2 : 32'd0);
            if (c >= 7) check($sformatf("abort result c%0d", c), result, 32'd55);
        end
        $display("op abort fib20: busy=%0d done=%0d result=%0d", busy, done, result);

        run_op("lucas10", 10, 32'd1, 32'd123, 1'b0, 1'b0, 11, 0, 1'b0);
        run_op("lucas0+abort", 0, 32'd1, 32'd2, 1'b0, 1'b0, 2, 0, 1'b1);
        run_op("trib10+start", 10, 32'd2, 32'd81, 1'b0, 1'b0, 10, 4, 1'b0);
        run_op("trib2", 2, 32'd2, 32'd1, 1'b0, 1'b0, 2, 0, 1'b0);
        run_op("pell7+finstart", 7, 32'd3, 32'd169, 1'b0, 1'b0, 8, 8, 1'b0);
        run_op("pell2 hi-b", 2, 32'hFFFF_FFF3, 32'd2, 1'b0, 1'b0, 3, 0, 1'b0);
        run_op("fib47", 47, 32'd0, 32'd2971215073, 1'b0, 1'b0, 48, 0, 1'b0);
        run_op("fib48", 48, 32'd0, 32'd512559680, 1'b1, 1'b0, 49, 0, 1'b0);
        run_op("fib1024", 1024, 32'd0, 32'd0, 1'b0, 1'b1, 2, 0, 1'b0);
        run_op("fib5", 5, 32'd0, 32'd5, 1'b0, 1'b0, 6, 0, 1'b0);
        run_op("pell12", 12, 32'd3, 32'd13860, 1'b0, 1'b0, 13, 0, 1'b0);

        // Reset mid-CALC: outputs clear without waiting for a clock edge
        @(negedge clk);
        start     = 1'b1;
        operand_a = 32'd20;
        operand_b = 32'd0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        check("pre-reset busy", {31'b0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset busy/done", {30'b0, busy, done}, 32'd0);
        check("async reset result", result, 32'd0);
        check("async reset ovf/err", {30'b0, ovf, err}, 32'd0);
        $display("op reset mid-calc: busy=%0d done=%0d result=%0d", busy, done, result);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post-reset idle", {30'b0, busy, done}, 32'd0);

        run_op("trib3", 3, 32'd2, 32'd1, 1'b0, 1'b0, 3, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
